// File: rtl/pipeline_pkg.sv
// Shared types for the decoupled fetch front end: fetch FSM states and queue entry layout.
package pipeline_pkg;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry queue of fetched words. Clear beats push and pop; pop of an empty queue is ignored.
module fetch_fifo
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  fetch_entry_t             wr_entry,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wptr, rptr;
  logic           do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rptr];

  // Pointers are PW bits wide so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= wptr + PW'(1);
      if (do_pop) rptr <= rptr + PW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wptr] <= wr_entry;
  end
endmodule

// File: rtl/fetch_prefetch_queue.sv
// Decoupled instruction fetch: one outstanding imem request feeding a small prefetch queue
// that presents its head to IF2ID, with branch redirect and flush of in-flight words.
module fetch_prefetch_queue
  import pipeline_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          ADDR_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [ADDR_W-1:0]      branch_addr,
  output logic                   imem_req,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  output logic                   if_valid,
  output logic [31:0]            if_instr,
  output logic [31:0]            if_pc,
  output logic [$clog2(DEPTH):0] q_count
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t      state, state_nx;
  logic [ADDR_W-1:0] fetch_pc, pc_nx, req_addr, pc_plus4;
  logic              req_c, push, pop, full;
  fetch_entry_t      head, wr_entry;

  assign full     = (q_count == CW'(DEPTH));
  assign pc_plus4 = fetch_pc + ADDR_W'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_nx;
      fetch_pc <= pc_nx;
      if (state == IDLE) req_addr <= fetch_pc;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = fetch_pc;
    req_c    = 1'b0;
    push     = 1'b0;
    case (state)
      IDLE: begin
        if (branch_taken) begin
          pc_nx = branch_addr;
        end else if (!full) begin
          req_c = 1'b1;
          // Zero-wait ack completes the handshake in the issue cycle.
          if (imem_ack) begin
            push  = 1'b1;
            pc_nx = pc_plus4;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        req_c = 1'b1;
        if (imem_ack) begin
          state_nx = IDLE;
          if (branch_taken) pc_nx = branch_addr;
          else begin
            push  = 1'b1;
            pc_nx = pc_plus4;
          end
        end else if (branch_taken) begin
          state_nx = DROP;
          pc_nx    = branch_addr;
        end
      end
      DROP: begin
        // The stale request still has to finish its handshake; its data is thrown away.
        req_c = 1'b1;
        if (branch_taken) pc_nx = branch_addr;
        if (imem_ack)     state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign imem_req  = req_c & ~rst;
  assign imem_addr = (state == IDLE) ? fetch_pc : req_addr;

  assign wr_entry = '{instr: imem_rdata, pc: 32'(pc_plus4)};
  assign pop      = if_valid & ~freeze & ~branch_taken;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .clear    (branch_taken),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (q_count)
  );

  assign if_valid = (q_count != '0);
  assign if_instr = if_valid ? head.instr : NOP_INSTR;
  assign if_pc    = if_valid ? head.pc    : 32'h0;
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: reactive imem with programmable ack delay, a queue-based
// reference model, a vector table for the free-run/freeze case and directed redirect/reset cases.
module tb_fetch_prefetch_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0, rst = 1'b1, freeze = 1'b0, branch_taken = 1'b0;
  logic [31:0]   branch_addr = 32'h0;
  logic          imem_req, imem_ack = 1'b0;
  logic [31:0]   imem_addr, imem_rdata = 32'h0;
  logic          if_valid;
  logic [31:0]   if_instr, if_pc;
  logic [CW-1:0] q_count;

  fetch_prefetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .q_count(q_count)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_pc, m_out_addr, exp_next;
  bit          m_out, m_stale;
  int          lat, cur_delay;
  bit          rnd_delay;
  bit          pre_req, pre_ack;
  logic [31:0] pre_addr;

  typedef struct {
    bit fr; bit req; logic [31:0] addr; bit valid; logic [31:0] pc; logic [31:0] cnt;
  } vec_t;
  vec_t tbl[18];

  function automatic vec_t mk(bit fr, bit req, int addr, int pc, int cnt);
    vec_t v;
    v.fr = fr; v.req = req; v.addr = 32'(addr); v.valid = 1'b1;
    v.pc = 32'(pc); v.cnt = 32'(cnt);
    return v;
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[31:16] ^ 16'h5A5A, a[17:2]};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc = 32'h0; m_out = 0; m_stale = 0; lat = 0; exp_next = 32'h4;
  endtask

  // One clock cycle: drive inputs, answer imem, advance the model, compare outputs.
  task automatic step(input bit fr, input bit br, input logic [31:0] ba);
    bit          p_req, ack, do_pop;
    logic [31:0] p_addr;
    int          n;
    @(negedge clk);
    freeze = fr; branch_taken = br; branch_addr = ba;
    #1;
    p_req  = m_out || (!br && m_q.size() < DEPTH);
    p_addr = m_out ? m_out_addr : m_pc;
    check("imem_req", 32'(imem_req), 32'(p_req));
    if (p_req) check("imem_addr", imem_addr, p_addr);
    ack        = imem_req && (lat >= cur_delay);
    pre_req    = imem_req; pre_addr = imem_addr; pre_ack = ack;
    imem_ack   = ack;
    imem_rdata = ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    // Consumed pcs must run +4 apart, restarting at target+4 after a redirect.
    if (if_valid && !fr && !br) begin
      check("seq_pc", if_pc, exp_next);
      exp_next = if_pc + 32'd4;
    end
    if (br) exp_next = ba + 32'd4;
    do_pop = m_q.size() > 0 && !fr && !br;
    if (br) m_q.delete();
    else if (do_pop) void'(m_q.pop_front());
    if (p_req && ack) begin
      if (!m_stale && !br) begin
        m_q.push_back('{mem_word(p_addr), p_addr + 32'd4});
        m_pc = p_addr + 32'd4;
      end
      m_out = 0; m_stale = 0;
    end else if (p_req && !m_out) begin
      m_out = 1; m_out_addr = p_addr;
    end
    if (br) begin
      m_pc = ba;
      if (m_out) m_stale = 1;
    end
    @(posedge clk);
    if (pre_req && pre_ack) begin
      lat = 0;
      if (rnd_delay) cur_delay = $urandom_range(0, 3);
    end else if (pre_req) lat++;
    else lat = 0;
    #1;
    imem_ack = 1'b0;
    n = m_q.size();
    check("if_valid", 32'(if_valid), 32'(n > 0));
    check("if_instr", if_instr, (n > 0) ? m_q[0].instr : 32'h0);
    check("if_pc", if_pc, (n > 0) ? m_q[0].pc : 32'h0);
    check("q_count", 32'(q_count), 32'(n));
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_req"},   32'(imem_req), 32'h0);
    check({tag, "_valid"}, 32'(if_valid), 32'h0);
    check({tag, "_instr"}, if_instr, 32'h0);
    check({tag, "_pc"},    if_pc, 32'h0);
    check({tag, "_count"}, 32'(q_count), 32'h0);
  endtask

  task automatic do_reset(input int d);
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("rst");
    @(posedge clk); #2;
    rst = 1'b0;
    model_reset();
    cur_delay = d; rnd_delay = 0;
  endtask

  initial begin
    int k;
    bit seen;
    // Zero-wait free run, then freeze until full, then release.
    for (int i = 0; i < 4; i++)   tbl[i] = mk(0, 1, 4 * i, 4 * (i + 1), 1);
    for (int i = 4; i < 14; i++)  tbl[i] = mk(1, i < 7, 16 + 4 * (i - 4), 16, (i < 7) ? i - 2 : 4);
    for (int i = 14; i < 18; i++) tbl[i] = mk(0, i > 14, 28 + 4 * (i - 15), 20 + 4 * (i - 14), 3);

    do_reset(0);
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].fr, 1'b0, 32'h0);
      check("tbl_req", 32'(pre_req), 32'(tbl[i].req));
      if (tbl[i].req) check("tbl_addr", pre_addr, tbl[i].addr);
      check("tbl_valid", 32'(if_valid), 32'(tbl[i].valid));
      check("tbl_pc", if_pc, tbl[i].pc);
      check("tbl_cnt", 32'(q_count), tbl[i].cnt);
    end

    // Redirect while a slow request is outstanding: stale word dropped.
    do_reset(3);
    step(0, 0, 32'h0);
    step(0, 1, 32'h100);
    step(0, 0, 32'h0);
    check("drop_hold_req", 32'(pre_req), 32'h1);
    check("drop_hold_addr", pre_addr, 32'h0);
    step(0, 0, 32'h0);
    check("drop_ack", 32'(pre_ack), 32'h1);
    check("drop_no_push", 32'(if_valid), 32'h0);
    step(0, 0, 32'h0);
    check("redirect_addr", pre_addr, 32'h100);
    seen = 0;
    for (k = 0; k < 10 && !seen; k++) begin
      if (if_valid) seen = 1;
      else step(0, 0, 32'h0);
    end
    check("redirect_seen", 32'(seen), 32'h1);
    check("redirect_first_pc", if_pc, 32'h104);

    // Branch together with ack and a pop at high occupancy.
    do_reset(0);
    repeat (3) step(1, 0, 32'h0);
    cur_delay = 2;
    step(1, 0, 32'h0);
    step(1, 0, 32'h0);
    step(0, 1, 32'h200);
    check("flush_ack", 32'(pre_ack), 32'h1);
    check("flush_count", 32'(q_count), 32'h0);
    check("flush_valid", 32'(if_valid), 32'h0);
    check("flush_instr", if_instr, 32'h0);
    cur_delay = 0;
    step(0, 0, 32'h0);
    check("flush_first_pc", if_pc, 32'h204);

    // Flush of a completely full queue.
    do_reset(0);
    repeat (4) step(1, 0, 32'h0);
    check("full_count", 32'(q_count), 32'(DEPTH));
    step(0, 1, 32'h300);
    check("full_flush_count", 32'(q_count), 32'h0);

    // Reset pulse during an outstanding request with three entries queued.
    do_reset(0);
    repeat (3) step(1, 0, 32'h0);
    cur_delay = 5;
    step(1, 0, 32'h0);
    check("pre_rst_count", 32'(q_count), 32'h3);
    #1 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    @(posedge clk); #2;
    rst = 1'b0;
    model_reset();
    cur_delay = 0;
    step(0, 0, 32'h0);
    check("restart_addr", pre_addr, 32'h0);
    check("restart_pc", if_pc, 32'h4);

    // Random freeze / redirect / ack delay against the model.
    do_reset(0);
    rnd_delay = 1;
    for (int i = 0; i < 800; i++) begin
      bit          fr, br;
      logic [31:0] ba;
      fr = ($urandom_range(0, 9) < 3);
      br = ($urandom_range(0, 19) == 0);
      ba = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : (32'($urandom_range(0, 1023)) << 2);
      step(fr, br, ba);
      check("q_bound", 32'(q_count <= CW'(DEPTH)), 32'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
